// File: rtl/spram_rr_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
// Build option SPRAM_ARB_RSP_REG_EN adds a register stage on the read response.
package spram_arb_pkg;

  localparam int ARB_DATA_W  = 8;
  localparam int ARB_DEPTH   = 16;
  localparam int ARB_ADDR_W  = $clog2(ARB_DEPTH);
  localparam int ARB_MAX_REQ = 32;

`ifdef SPRAM_ARB_RSP_REG_EN
  localparam int RSP_LATENCY = 2;
`else
  localparam int RSP_LATENCY = 1;
`endif

  // One RAM access; sized to the default RAM geometry.
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  // First valid requester after 'last', wrapping modulo n; onehot or zero.
  function automatic logic [ARB_MAX_REQ-1:0] rr_next(
    input logic [ARB_MAX_REQ-1:0] valid,
    input int unsigned            last,
    input int unsigned            n
  );
    logic                           found;
    int unsigned                    idx;
    logic [$clog2(ARB_MAX_REQ)-1:0] sel;
    rr_next = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAX_REQ; k++) begin
      if (k <= n && !found) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        sel = $clog2(ARB_MAX_REQ)'(idx);
        if (valid[sel]) begin
          rr_next[sel] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/spram_rr_arbiter_if.sv
// Requester-side bus of the spram arbiter: valid/ready access requests and
// the shared read-response strobe/data.
interface spram_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: valid vector and last owner in,
// onehot0 grant and its index out.
module rr_pick
  import spram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [ARB_MAX_REQ-1:0] g;

  always_comb begin
    g   = rr_next(ARB_MAX_REQ'(valid), 32'(last), N);
    gnt = g[N-1:0];
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++)
      if (g[i]) idx = IW'(i);
  end
endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// bounded burst per owner. SPRAM_ARB_RSP_REG_EN registers the read response.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int FIFO_DEPTH = ARB_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spram_rr_arbiter_if.slave     bus,
  output logic                  mem_en,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]      last_owner, rr_idx, gnt_idx;
  logic [CW-1:0]      burst_cnt;
  logic [NUM_REQ-1:0] rr_gnt, gnt, rd_q;
  logic               keep;
  mem_req_t           sel;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid (bus.req_valid),
    .last  (last_owner),
    .gnt   (rr_gnt),
    .idx   (rr_idx)
  );

  // burst_cnt holds grants taken in the current burst; 0 means no owner yet.
  always_comb begin
    keep    = bus.req_valid[last_owner] && burst_cnt != '0 && burst_cnt < CW'(MAX_BURST);
    gnt     = '0;
    gnt_idx = rr_idx;
    if (rst_n) begin
      if (keep) begin
        gnt[last_owner] = 1'b1;
        gnt_idx         = last_owner;
      end else begin
        gnt = rr_gnt;
      end
    end
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i])
        sel = '{we:    bus.req_we[i],
                addr:  ARB_ADDR_W'(bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                wdata: ARB_DATA_W'(bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH])};
  end

  assign bus.req_ready = gnt;
  assign mem_en        = |gnt;
  assign mem_wea       = sel.we;
  assign mem_addr      = ADDR_WIDTH'(sel.addr);
  assign mem_din       = DATA_WIDTH'(sel.wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      rd_q       <= '0;
    end else begin
      rd_q <= gnt & ~bus.req_we;
      if (|gnt) begin
        last_owner <= gnt_idx;
        // A fresh burst starts on owner change or when an exhausted owner is re-picked.
        if (gnt_idx != last_owner || burst_cnt == '0 || burst_cnt >= CW'(MAX_BURST))
          burst_cnt <= CW'(1);
        else
          burst_cnt <= burst_cnt + CW'(1);
      end
    end
  end

`ifdef SPRAM_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_q;
      if (|rd_q) rsp_data_q <= mem_dout;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`else
  assign bus.rsp_valid = rd_q;
  assign bus.rsp_data  = (|rd_q) ? mem_dout : '0;
`endif
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter: two instances (MAX_BURST 4 and 1),
// each backed by a behavioural 16x8 RAM with 1-cycle read latency.
module tb_spram_rr_arbiter;
  import spram_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int L  = RSP_LATENCY;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  spram_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  spram_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  logic          en_a, wea_a, en_b, wea_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;
  logic [DW-1:0] ram_a [16];
  logic [DW-1:0] ram_b [16];

  spram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .mem_en(en_a), .mem_wea(wea_a), .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a)
  );

  spram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .mem_en(en_b), .mem_wea(wea_b), .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b)
  );

  // RAM contents reload to 0x40+addr on every reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ram_a[i] <= 8'h40 + 8'(i);
        ram_b[i] <= 8'h40 + 8'(i);
      end
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (en_a) begin
        if (wea_a) ram_a[addr_a] <= din_a;
        dout_a <= ram_a[addr_a];
      end
      if (en_b) begin
        if (wea_b) ram_b[addr_b] <= din_b;
        dout_b <= ram_b[addr_b];
      end
    end
  end

  task automatic idle_inputs();
    bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
  endtask

  task automatic set_addrs(input int base);
    for (int i = 0; i < NR; i++) begin
      bus_a.req_addr[i*AW +: AW] = AW'(base + i);
      bus_b.req_addr[i*AW +: AW] = AW'(base + i);
    end
  endtask

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.req_valid = '1; bus_a.req_we = '1; bus_a.req_wdata = '1;
    set_addrs(5);
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", bus_a.req_ready); end
    n_cmp++; if ({en_a, wea_a} !== 2'b00) begin n_err++; $display("FAIL rst_en_wea got %b want 00", {en_a, wea_a}); end
    n_cmp++; if ({addr_a, din_a} !== 12'h000) begin n_err++; $display("FAIL rst_addr_din got %h want 000", {addr_a, din_a}); end
    n_cmp++; if (bus_a.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0000", bus_a.rsp_valid); end
    n_cmp++; if (bus_a.rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h want 00", bus_a.rsp_data); end
    idle_inputs();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_d;
    do_reset();
    bus_a.req_valid = 4'b0001; bus_a.req_we = 4'b0001;
    bus_a.req_addr[AW-1:0] = 4'd3; bus_a.req_wdata[DW-1:0] = 8'hA5;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_ready got %b want 0001", bus_a.req_ready); end
    n_cmp++; if ({en_a, wea_a, addr_a, din_a} !== {2'b11, 4'd3, 8'hA5}) begin
      n_err++; $display("FAIL wr_mem got %b %b %h %h want 1 1 3 a5", en_a, wea_a, addr_a, din_a); end
    @(negedge clk);
    bus_a.req_we = 4'b0000;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_ready got %b want 0001", bus_a.req_ready); end
    n_cmp++; if ({en_a, wea_a} !== 2'b10) begin n_err++; $display("FAIL rd_mem got %b want 10", {en_a, wea_a}); end
    n_cmp++; if (bus_a.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL wr_no_rsp got %b want 0000", bus_a.rsp_valid); end
    @(negedge clk);
    bus_a.req_valid = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      #1;
      exp_d = (k == L || (L > 1 && k > L)) ? 8'hA5 : 8'h00;
      n_cmp++; if (bus_a.rsp_valid !== ((k == L) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL rd_rsp_valid k=%0d got %b", k, bus_a.rsp_valid); end
      n_cmp++; if (bus_a.rsp_data !== exp_d) begin
        n_err++; $display("FAIL rd_rsp_data k=%0d got %h want %h", k, bus_a.rsp_data, exp_d); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] gh [20];
    logic [NR-1:0] exp;
    do_reset();
    bus_a.req_valid = 4'b1111;
    set_addrs(8);
    for (int c = 0; c < 20; c++) begin
      #1;
      exp = 4'b0001 << ((c / 4) % 4);
      gh[c] = exp;
      n_cmp++; if (bus_a.req_ready !== exp) begin
        n_err++; $display("FAIL rr_ready c=%0d got %b want %b", c, bus_a.req_ready, exp); end
      n_cmp++; if (bus_a.rsp_valid !== ((c >= L) ? gh[c-L] : 4'b0000)) begin
        n_err++; $display("FAIL rr_rsp_valid c=%0d got %b", c, bus_a.rsp_valid); end
      if (c >= L) begin
        n_cmp++; if (bus_a.rsp_data !== 8'h48 + 8'(((c - L) / 4) % 4)) begin
          n_err++; $display("FAIL rr_rsp_data c=%0d got %h", c, bus_a.rsp_data); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_one();
    logic [NR-1:0] gh [8];
    logic [NR-1:0] exp;
    do_reset();
    bus_b.req_valid = 4'b1010;
    set_addrs(8);
    for (int c = 0; c < 8; c++) begin
      #1;
      exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      gh[c] = exp;
      n_cmp++; if (bus_b.req_ready !== exp) begin
        n_err++; $display("FAIL mb1_ready c=%0d got %b want %b", c, bus_b.req_ready, exp); end
      n_cmp++; if (bus_b.rsp_valid !== ((c >= L) ? gh[c-L] : 4'b0000)) begin
        n_err++; $display("FAIL mb1_rsp_valid c=%0d got %b", c, bus_b.rsp_valid); end
      if (c >= L) begin
        n_cmp++; if (bus_b.rsp_data !== ((gh[c-L] == 4'b0010) ? 8'h49 : 8'h4B)) begin
          n_err++; $display("FAIL mb1_rsp_data c=%0d got %h", c, bus_b.rsp_data); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drop_mid_burst();
    logic [NR-1:0] exp;
    do_reset();
    bus_a.req_valid = 4'b0100;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0100) begin n_err++; $display("FAIL drop_g0 got %b want 0100", bus_a.req_ready); end
    @(negedge clk);
    bus_a.req_valid = 4'b0101;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0100) begin n_err++; $display("FAIL drop_g1 got %b want 0100", bus_a.req_ready); end
    @(negedge clk);
    bus_a.req_valid = 4'b0001;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0001) begin n_err++; $display("FAIL drop_switch got %b want 0001", bus_a.req_ready); end
    @(negedge clk);
    bus_a.req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp = (k < 3) ? 4'b0001 : 4'b0100;
      n_cmp++; if (bus_a.req_ready !== exp) begin
        n_err++; $display("FAIL drop_burst k=%0d got %b want %b", k, bus_a.req_ready, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_drops_rsp();
    do_reset();
    bus_a.req_valid = 4'b0010;
    set_addrs(0);
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0010) begin n_err++; $display("FAIL rdrop_ready got %b want 0010", bus_a.req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0000) begin n_err++; $display("FAIL rdrop_gate got %b want 0000", bus_a.req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rdrop_rsp got %b want 0000", bus_a.rsp_valid); end
    @(negedge clk);
    bus_a.req_valid = 4'b0011;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus_a.req_ready !== 4'b0001) begin n_err++; $display("FAIL rdrop_first got %b want 0001", bus_a.req_ready); end
    n_cmp++; if (bus_a.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rdrop_rsp2 got %b want 0000", bus_a.rsp_valid); end
    @(negedge clk);
    bus_a.req_valid = 4'b0000;
    for (int k = 1; k < L; k++) @(negedge clk);
    #1;
    n_cmp++; if (bus_a.rsp_valid !== 4'b0001) begin n_err++; $display("FAIL rdrop_new_rsp got %b want 0001", bus_a.rsp_valid); end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst_one();
    test_drop_mid_burst();
    test_reset_drops_rsp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
